// File: rtl/ledg_blink_sequencer_pkg.sv
// ledg_seq_pkg: shared definitions for the LEDG blink sequencer.
//   - CPU slave register offsets and CTRL/status bit positions
//   - sequencer FSM state encoding
//   - PIO data register offset used on the master port
package ledg_seq_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PATTERN = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_COUNT   = 2'd3;

    // CTRL write bits
    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_ABORT    = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_CLR_DONE = 3;

    // CTRL read bits
    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;
    localparam int unsigned STAT_IRQ_EN = 2;

    localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2,
        FINAL = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ledg_blink_sequencer_phase_timer.sv
// ledg_phase_timer: loadable down-counter timing one LED phase.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val (has priority over dec)
//   dec          : decrement, saturating at 0
//   load_val     : value to load
//   zero         : the decrement in this cycle brings the count to 0
module ledg_phase_timer #(
    parameter int unsigned PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  dec,
    input  logic [PRESCALE_W-1:0] load_val,
    output logic                  zero
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    // Flagging the last decrement (rather than the zero value itself) keeps
    // WRITE + HOLD cycles equal to the programmed period.
    assign zero = (cnt == ONE);

endmodule

// File: rtl/ledg_blink_sequencer.sv
// ledg_blink_sequencer: CPU-programmed LED pattern sequencer driving the
// LEDG PIO data register through single-cycle Avalon-MM writes.
//   clk, reset_n      : clock, asynchronous active-low reset
//   s_*               : CPU Avalon-MM slave (CTRL, PATTERN, PERIOD, COUNT)
//   s_readdata        : combinational read data
//   m_*               : Avalon-MM master to PIO s1 (data offset 0)
//   irq               : level interrupt, done & irq_en
module ledg_blink_sequencer
    import ledg_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 24,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic        irq
);

    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
    localparam logic [CNT_W-1:0]      C_ONE = CNT_W'(1);

    seq_state_e state, state_nxt;

    logic                  irq_en, done;
    logic [23:0]           pattern;
    logic [PRESCALE_W-1:0] period_reg, per_lat, per_lat_nxt;
    logic [CNT_W-1:0]      count_reg, cnt_lat, cnt_lat_nxt, k, k_nxt, k_inc;
    logic                  start_q, abort_q;
    logic                  aborted, aborted_nxt;
    logic                  busy, slv_wr, ctrl_wr, last_phase;
    logic                  tmr_load, tmr_dec, tmr_zero;
    logic [7:0]            pio_byte;
    logic                  wdata_unused;

    assign slv_wr  = s_chipselect && !s_write_n;
    assign ctrl_wr = slv_wr && (s_address == REG_CTRL);

    // START/ABORT are registered before the FSM sees them, so an accepted
    // START gives its first PIO write one cycle after acceptance.
    assign busy = start_q || (state != IDLE);

    assign wdata_unused = ^s_writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en     <= 1'b0;
            pattern    <= '0;
            period_reg <= '0;
            count_reg  <= '0;
            done       <= 1'b0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            aborted    <= 1'b0;
            per_lat    <= '0;
            cnt_lat    <= '0;
            k          <= '0;
            state      <= IDLE;
        end else begin
            if (slv_wr) begin
                case (s_address)
                    REG_CTRL:    irq_en     <= s_writedata[CTRL_IRQ_EN];
                    REG_PATTERN: pattern    <= s_writedata[23:0];
                    REG_PERIOD:  period_reg <= s_writedata[PRESCALE_W-1:0];
                    default:     count_reg  <= s_writedata[CNT_W-1:0];
                endcase
            end
            start_q <= ctrl_wr && s_writedata[CTRL_START]
                       && !s_writedata[CTRL_ABORT] && !busy;
            abort_q <= ctrl_wr && s_writedata[CTRL_ABORT] && busy;
            if ((state == FINAL) && !aborted) begin
                done <= 1'b1;
            end else if (ctrl_wr && s_writedata[CTRL_CLR_DONE]) begin
                done <= 1'b0;
            end
            aborted <= aborted_nxt;
            per_lat <= per_lat_nxt;
            cnt_lat <= cnt_lat_nxt;
            k       <= k_nxt;
            state   <= state_nxt;
        end
    end

    assign k_inc      = k + C_ONE;
    assign last_phase = (cnt_lat != '0) && (k_inc == cnt_lat);

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        aborted_nxt = aborted;
        per_lat_nxt = per_lat;
        cnt_lat_nxt = cnt_lat;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        case (state)
            IDLE: begin
                if (start_q) begin
                    per_lat_nxt = (period_reg == '0) ? P_ONE : period_reg;
                    cnt_lat_nxt = count_reg;
                    k_nxt       = '0;
                    aborted_nxt = 1'b0;
                    state_nxt   = WRITE;
                end
            end
            WRITE: begin
                tmr_load = 1'b1;
                if (abort_q) begin
                    aborted_nxt = 1'b1;
                    state_nxt   = FINAL;
                end else if (per_lat == P_ONE) begin
                    k_nxt     = k_inc;
                    state_nxt = last_phase ? FINAL : WRITE;
                end else begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                tmr_dec = 1'b1;
                if (abort_q) begin
                    aborted_nxt = 1'b1;
                    state_nxt   = FINAL;
                end else if (tmr_zero) begin
                    k_nxt     = k_inc;
                    state_nxt = last_phase ? FINAL : WRITE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    ledg_phase_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (per_lat - P_ONE),
        .zero     (tmr_zero)
    );

    always_comb begin
        pio_byte = '0;
        case (state)
            WRITE:   pio_byte = k[0] ? pattern[15:8] : pattern[7:0];
            FINAL:   pio_byte = pattern[23:16];
            default: pio_byte = '0;
        endcase
    end

    assign m_address    = PIO_DATA_OFFSET;
    assign m_chipselect = (state == WRITE) || (state == FINAL);
    assign m_write_n    = !m_chipselect;
    assign m_writedata  = {24'b0, pio_byte};
    assign irq          = done && irq_en;

    always_comb begin
        s_readdata = '0;
        case (s_address)
            REG_CTRL: begin
                s_readdata[STAT_BUSY]   = busy;
                s_readdata[STAT_DONE]   = done;
                s_readdata[STAT_IRQ_EN] = irq_en;
            end
            REG_PATTERN: s_readdata[23:0]           = pattern;
            REG_PERIOD:  s_readdata[PRESCALE_W-1:0] = period_reg;
            default:     s_readdata[CNT_W-1:0]      = count_reg;
        endcase
    end

endmodule

// File: doc/ledg_blink_sequencer.md
# ledg_blink_sequencer

Hardware sequencer that drives the green-LED PIO output port so firmware does not bit-bang LED patterns. Sits between the Nios II data master and the LEDG PIO register: the CPU programs patterns, phase period and phase count over an Avalon-MM slave. The block then issues timed single-cycle Avalon-MM writes to the PIO `s1` data register (offset 0), alternating two patterns, and finishes with a final pattern, a done flag and an optional interrupt. Typical use is pass/fail indication in the password checker.

## Interface
Parameters:
- `PRESCALE_W`, 24, width of the phase-period counter (cycles per phase).
- `CNT_W`, 16, width of the phase counter.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_address` in 2: CPU register select.
- `s_chipselect` in 1: CPU slave select.
- `s_write_n` in 1: CPU write strobe, active-low.
- `s_writedata` in 32: CPU write data.
- `s_readdata` out 32: combinational read data, zero wait states.
- `m_address` out 2: PIO address, constant 0.
- `m_chipselect` out 1: PIO select, asserted only during write cycles.
- `m_write_n` out 1: PIO write strobe, active-low.
- `m_writedata` out 32: `{24'b0, pattern}`.
- `irq` out 1: level interrupt, `done & irq_en`.

## Operation
Registers (all reset to 0):
- **0 CTRL.**
  - Write: bit0 START (pulse), bit1 ABORT (pulse), bit2 IRQ_EN (stored), bit3 CLR_DONE (pulse).
  - Read: bit0 busy, bit1 done, bit2 irq_en.
- **1 PATTERN.** [7:0] pattern A, [15:8] pattern B, [23:16] final pattern.
- **2 PERIOD.** [PRESCALE_W-1:0] cycles per phase. A value of 0 is treated as 1.
- **3 COUNT.** [CNT_W-1:0] number of A/B phases. A value of 0 means run until ABORT.
- Reads of unimplemented bits return 0.

FSM states:
- **IDLE.** START moves to WRITE. PERIOD and COUNT are latched, phase index k=0, busy=1.
- **WRITE.**
  - One cycle. Master write of A (k even) or B (k odd), using the current PATTERN value.
  - Period counter loads PERIOD-1.
  - If PERIOD=1, go to WRITE again, or FINAL if phases are exhausted. Otherwise go to HOLD.
- **HOLD.** Period counter decrements. At 0, k increments. If k == latched COUNT (COUNT≠0), go to FINAL; otherwise go to WRITE.
- **FINAL.** One-cycle master write of the final pattern. Sets done=1, busy=0, then goes to IDLE.

Rules:
- START while busy is ignored.
- ABORT while busy: next state is FINAL and done stays 0. ABORT in IDLE has no effect.
- START and ABORT in the same write: ABORT wins, no run starts.
- CLR_DONE clears done in the same write that sets irq_en; done set by FINAL in the same cycle as CLR_DONE stays set (set wins).
- PATTERN writes during a run take effect at the next WRITE/FINAL. PERIOD and COUNT writes take effect at the next START.
- k wraps modulo 2^CNT_W when COUNT=0.
- `m_chipselect` and `!m_write_n` are asserted together, for exactly one cycle per PIO write, and are never asserted in IDLE or HOLD.

## Timing
- Reset: all registers 0, FSM IDLE, busy=0, done=0, irq=0, `m_chipselect`=0, `m_write_n`=1, `m_writedata`=0, `s_readdata` reflects zeroed registers. Asynchronous assertion mid-run returns to IDLE immediately, with no trailing PIO write.
- START accepted at clock edge T: first PIO write is active in cycle T+1, so the LED updates at edge T+2.
- Successive PIO writes are exactly PERIOD cycles apart.
- Final write occurs PERIOD cycles after the last A/B write. done, busy=0 and irq are visible the cycle after the final write.
- ABORT accepted at edge T: final write occurs in cycle T+1.
- Slave writes complete in one cycle; reads are combinational from `s_address`.

## Structure
- Package `ledg_seq_pkg` holds:
  - register offsets: CTRL=0, PATTERN=1, PERIOD=2, COUNT=3;
  - CTRL bit indices;
  - the FSM state enum {IDLE, WRITE, HOLD, FINAL};
  - the PIO data offset constant 0.
- One sub-module, `ledg_phase_timer`: a loadable PRESCALE_W down-counter with `load`, `load_val` and `zero` outputs.
- The top level holds the register file, FSM, phase counter and master-port drive.

## Test plan
- Reset mid-run: start run, assert reset_n=0 during HOLD → all outputs return to their reset values at once, with no further PIO writes after release.
- PATTERN=0x3C_F0_0F, PERIOD=4, COUNT=3, START → PIO writes 0x0F, 0xF0, 0x0F, 0x3C at cycles T+1, T+5, T+9, T+13; done=1 at T+14.
- PERIOD=0, COUNT=2 → writes A, B, final on three consecutive cycles.
- COUNT=0, PERIOD=2, ABORT after 5 writes → final pattern written the next cycle, done=0, busy=0.
- IRQ_EN=1, run to completion → irq=1; CTRL write of CLR_DONE → irq=0 the next cycle.
- START while busy, and START+ABORT in one write → no restart, no new run; PATTERN rewritten mid-run → new A/B used at the next write.
